if_id_buffer: RTL and testbench
===============================

# if_id_buffer

Two-entry elastic buffer between the instruction fetch stage and the decode stage of the pipelined ARMv8 core. It is the receiving end of the fetch interface:
- it captures the instruction word, PC and PC+4 (branch-link) value produced by fetch;
- it drives fetch's `PCWrite` through `ready_out`;
- it presents entries in order to decode.

Decode back-pressure from the hazard unit (`stall`) and branch flushes (`flush`) are absorbed here. Fetch needs no combinational path from decode.

## Interface
- `PC_WIDTH`, 64, width of PC and branch-link fields
- `NOP_INSTR`, 32'hD503201F, instruction word driven when no valid entry is presented (ARMv8 NOP)

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low
- `valid_in`  in  1  fetch presents a valid instruction this cycle
- `instruction_in`  in  32  fetched instruction word
- `PC_in`  in  `PC_WIDTH`  address of `instruction_in`
- `PC_branch_link_in`  in  `PC_WIDTH`  `PC_in`+4 from fetch
- `ready_out`  out  1  buffer can accept; drives fetch `PCWrite`
- `stall`  in  1  decode cannot consume this cycle (hazard unit)
- `flush`  in  1  branch taken (`or_out` | `Branchreg`); discard all entries
- `valid_out`  out  1  decode outputs hold a valid entry
- `instruction_out`  out  32  head instruction, or `NOP_INSTR` when `valid_out`=0
- `PC_out`  out  `PC_WIDTH`  head PC, or 0 when `valid_out`=0
- `PC_branch_link_out`  out  `PC_WIDTH`  head PC+4, or 0 when `valid_out`=0

## Operation
- **Storage:** 2 entries of {instr, PC, PC+4}, 1-bit `wr_ptr`/`rd_ptr` (wrap 1→0), 2-bit `count` (0..2).
- **Outputs:**
  - `ready_out` = (`count` != 2); depends only on registered state.
  - `valid_out` = (`count` != 0) && !`flush`.
- **Push:** `valid_in` && `ready_out` && !`flush`. Write the entry at `wr_ptr`, then toggle `wr_ptr`.
- **Pop:** `valid_out` && !`stall`. Toggle `rd_ptr`.
- **Count update:**
  - push only: `count`+1
  - pop only: `count`-1
  - both: unchanged. Legal at `count`=1; at `count`=2 push cannot occur.
- **Flush:** at the next edge, `count`=0 and `rd_ptr`=`wr_ptr`=0. Any push in the same cycle is discarded. `valid_out` is forced low combinationally during the flush cycle, so decode never consumes a squashed instruction.
- **Stall:** with `stall`=1 the head entry is held stable on the outputs. Fetch keeps pushing until `count`=2, then `ready_out` drops and fetch freezes its PC.
- **Output data:** entry at `rd_ptr` when `valid_out`=1, else the NOP/0 values. Stored data is not altered by flush, only invalidated.
- **Reset (asynchronous, active-low):**
  - `count`=0, both pointers 0, storage cleared to NOP/0;
  - outputs: `ready_out`=1, `valid_out`=0, `instruction_out`=`NOP_INSTR`, `PC_out`=0, `PC_branch_link_out`=0.

## Timing
- **Latency:** an entry pushed at edge N is on the outputs after edge N (valid during cycle N+1) when the buffer was empty.
- **Throughput:** 1 entry/cycle with `stall`=0. The buffer sits steady at `count`=1 with push and pop every cycle.
- **Back-pressure:** `ready_out` falls in the cycle after the edge that makes `count`=2. It rises in the cycle after the first pop from full.
- **Flush priority:** `flush` overrides push, pop and `stall`. `ready_out` returns to 1 the cycle after the flush edge.
- **Reset mid-operation:** state clears without waiting for a clock edge, and outputs take reset values in the same cycle. Normal operation resumes at the first edge after `reset` returns high.

## Test plan
- **Reset:** drive `reset`=0 mid-stream with `count`=2.
  - Required: immediately `valid_out`=0, `instruction_out`=32'hD503201F, `PC_out`=0, `ready_out`=1.
- **Streaming:**
  - Stimulus: push PC 0x0, 0x4, 0x8, 0xC on consecutive cycles, `stall`=0.
  - Required: `PC_out` shows 0x0, 0x4, 0x8, 0xC one cycle later each; `PC_branch_link_out` = PC+4; `count` stays 1.
- **Stall fill:**
  - Stimulus: hold `stall`=1 while pushing 0x100, 0x104, 0x108.
  - Required: `ready_out`=0 after the second push, so 0x108 is not accepted; head stays 0x100.
  - After `stall`=0: outputs 0x100, then 0x104, then 0x108 once fetch re-presents it.
- **Flush with push:**
  - Stimulus: at `count`=2 assert `flush` together with `valid_in` (PC 0x200).
  - Required: `valid_out`=0 that cycle; next cycle `count`=0, `ready_out`=1; 0x200 is not stored.
- **Pointer wrap:**
  - Stimulus: alternate push-only and push+pop for 8 cycles with distinct instruction words.
  - Required: output order matches input order exactly; no duplicated or lost entry across the 1→0 pointer wrap.

Source files
------------

// File: rtl/if_id_buffer_if.sv
// ----------------------------------------------------------------------------
// if_id_buffer_if
// Purpose : bundles the fetch-side and decode-side signals of the IF/ID
//           elastic buffer.
// Modports: slave  - the buffer (receives fetch + hazard controls, drives decode)
//           master - the environment (fetch / hazard unit / decode)
// Signals : valid_in, instruction_in, PC_in, PC_branch_link_in, ready_out
//           (fetch side); stall, flush (control); valid_out, instruction_out,
//           PC_out, PC_branch_link_out (decode side)
// ----------------------------------------------------------------------------
interface if_id_buffer_if #(
    parameter int PC_WIDTH = 64
);
    logic                valid_in;
    logic [31:0]         instruction_in;
    logic [PC_WIDTH-1:0] PC_in;
    logic [PC_WIDTH-1:0] PC_branch_link_in;
    logic                ready_out;
    logic                stall;
    logic                flush;
    logic                valid_out;
    logic [31:0]         instruction_out;
    logic [PC_WIDTH-1:0] PC_out;
    logic [PC_WIDTH-1:0] PC_branch_link_out;

    modport slave (
        input  valid_in, instruction_in, PC_in, PC_branch_link_in, stall, flush,
        output ready_out, valid_out, instruction_out, PC_out, PC_branch_link_out
    );

    modport master (
        output valid_in, instruction_in, PC_in, PC_branch_link_in, stall, flush,
        input  ready_out, valid_out, instruction_out, PC_out, PC_branch_link_out
    );
endinterface

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Purpose : two-entry elastic buffer between instruction fetch and decode.
//           Captures {instruction, PC, PC+4} from fetch, drives fetch PCWrite
//           via ready_out, presents entries in order to decode. Absorbs
//           decode stalls and branch flushes.
// Ports   : clock - rising-edge clock
//           reset - asynchronous, active-low
//           bus   - if_id_buffer_if.slave (fetch, control and decode signals)
// ----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int          PC_WIDTH  = 64,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic         clock,
    input  logic         reset,
    if_id_buffer_if.slave bus
);
    logic [31:0]         r_instr [2];
    logic [PC_WIDTH-1:0] r_pc    [2];
    logic [PC_WIDTH-1:0] r_pc_bl [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // ready depends only on registered state, so fetch never sees a
    // combinational path from decode's stall.
    assign w_ready = (r_count != 2'd2);
    // Squash the head during a flush cycle so decode cannot consume it.
    assign w_valid = (r_count != 2'd0) && !bus.flush;
    assign w_push  = bus.valid_in && w_ready && !bus.flush;
    assign w_pop   = w_valid && !bus.stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= NOP_INSTR;
                r_pc[i]    <= '0;
                r_pc_bl[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (bus.flush) begin
            // Stored data is left in place; only the bookkeeping is cleared.
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= bus.instruction_in;
                r_pc[r_wr_ptr]    <= bus.PC_in;
                r_pc_bl[r_wr_ptr] <= bus.PC_branch_link_in;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.ready_out          = w_ready;
    assign bus.valid_out          = w_valid;
    assign bus.instruction_out    = w_valid ? r_instr[r_rd_ptr] : NOP_INSTR;
    assign bus.PC_out             = w_valid ? r_pc[r_rd_ptr]    : '0;
    assign bus.PC_branch_link_out = w_valid ? r_pc_bl[r_rd_ptr] : '0;
endmodule

// File: tb/tb_if_id_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_id_buffer
// Purpose : self-checking bench for if_id_buffer. A queue holds the entries
//           the buffer should contain; outputs are compared to its head each
//           cycle and entries are removed when decode consumes them.
// ----------------------------------------------------------------------------
module tb_if_id_buffer;
    localparam int          PC_WIDTH = 64;
    localparam logic [31:0] NOP      = 32'hD503201F;

    typedef struct {
        logic [31:0]         ins;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_err;
    entry_t sb [$];

    if_id_buffer_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    if_id_buffer #(.PC_WIDTH(PC_WIDTH), .NOP_INSTR(NOP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check outputs against the
    // scoreboard, then update the scoreboard for the coming rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic st, input logic fl, output logic acc);
        logic exp_rdy;
        logic exp_vld;
        entry_t e;
        @(negedge clock);
        bus.valid_in          = v;
        bus.instruction_in    = ins;
        bus.PC_in             = pc;
        bus.PC_branch_link_in = pc + 64'd4;
        bus.stall             = st;
        bus.flush             = fl;
        exp_rdy = (sb.size() != 2);
        exp_vld = (sb.size() != 0) && !fl;
        #1;
        chk("ready_out", bus.ready_out, exp_rdy);
        chk("valid_out", bus.valid_out, exp_vld);
        if (exp_vld) begin
            e = sb[0];
            chk("instruction_out", bus.instruction_out, e.ins);
            chk("PC_out", bus.PC_out, e.pc);
            chk("PC_branch_link_out", bus.PC_branch_link_out, e.pc + 64'd4);
        end else begin
            chk("instruction_out_nop", bus.instruction_out, NOP);
            chk("PC_out_zero", bus.PC_out, 64'd0);
            chk("PC_bl_out_zero", bus.PC_branch_link_out, 64'd0);
        end
        acc = v && exp_rdy && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (exp_vld && !st) void'(sb.pop_front());
            if (acc) begin
                e.ins = ins;
                e.pc  = pc;
                sb.push_back(e);
            end
        end
        @(posedge clock);
    endtask

    task automatic idle(input logic st);
        logic a;
        step(1'b0, 32'h0, 64'h0, st, 1'b0, a);
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sb.size() != 0; i++) idle(1'b0);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic a;
        int   j;
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.valid_in = 1'b0; bus.instruction_in = '0; bus.PC_in = '0;
        bus.PC_branch_link_in = '0; bus.stall = 1'b0; bus.flush = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", bus.ready_out, 1'b1);
        chk("rst_valid", bus.valid_out, 1'b0);
        chk("rst_instr", bus.instruction_out, NOP);
        chk("rst_pc", bus.PC_out, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Streaming: push+pop every cycle at one entry
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'hE000_0000 | 32'(i * 4), 64'(i * 4), 1'b0, 1'b0, a);
        idle(1'b0);
        idle(1'b0);

        // Stall fill: third push refused, fetch re-presents 0x108
        step(1'b1, 32'hE000_0100, 64'h100, 1'b1, 1'b0, a);
        step(1'b1, 32'hE000_0104, 64'h104, 1'b1, 1'b0, a);
        step(1'b1, 32'hE000_0108, 64'h108, 1'b1, 1'b0, a);
        a = 1'b0;
        for (int i = 0; i < 4 && !a; i++)
            step(1'b1, 32'hE000_0108, 64'h108, 1'b0, 1'b0, a);
        drain();

        // Flush at count=2 together with a push of 0x200
        step(1'b1, 32'hE000_0180, 64'h180, 1'b1, 1'b0, a);
        step(1'b1, 32'hE000_0184, 64'h184, 1'b1, 1'b0, a);
        step(1'b1, 32'hE000_0200, 64'h200, 1'b0, 1'b1, a);
        idle(1'b0);
        idle(1'b0);

        // Pointer wrap: alternate push-only and push+pop, re-present on refusal
        j = 0;
        for (int i = 0; i < 16 && j < 8; i++) begin
            step(1'b1, 32'hA5A5_0000 + 32'(j), 64'h300 + 64'(j * 4), (i % 2) == 0, 1'b0, a);
            if (a) j++;
        end
        chk("wrap_all_accepted", j, 8);
        drain();

        // Asynchronous reset mid-stream with count=2
        step(1'b1, 32'hE000_0400, 64'h400, 1'b1, 1'b0, a);
        step(1'b1, 32'hE000_0404, 64'h404, 1'b1, 1'b0, a);
        @(negedge clock);
        bus.valid_in = 1'b0;
        bus.stall    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.valid_out, 1'b0);
        chk("mid_rst_instr", bus.instruction_out, NOP);
        chk("mid_rst_pc", bus.PC_out, 64'd0);
        chk("mid_rst_ready", bus.ready_out, 1'b1);
        sb.delete();
        #1;
        reset = 1'b1;
        idle(1'b0);
        step(1'b1, 32'hE000_0500, 64'h500, 1'b0, 1'b0, a);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
